// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: PC, instruction memory and the IF/ID register.
// Supports program loading, free-run and single-step operation, and halts on HALT_WORD.
module instruction_fetch_stage #(
  parameter int NBITS = 32,
  parameter int MEM_DEPTH = 64,
  parameter int ADDR_BITS = $clog2(MEM_DEPTH),
  parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load_en,
  input  logic [ADDR_BITS-1:0] i_load_addr,
  input  logic [NBITS-1:0]     i_load_data,
  input  logic                 i_start,
  input  logic                 i_step_mode,
  input  logic                 i_step,
  input  logic                 i_stall,
  input  logic                 i_flg_jump_taken,
  input  logic [NBITS-1:0]     i_jump_addr,
  output logic [NBITS-1:0]     o_pc,
  output logic [NBITS-1:0]     o_instruction,
  output logic                 o_valid,
  output logic [NBITS-1:0]     o_cur_pc,
  output logic                 o_halted
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [NBITS-1:0] PC_INC  = {{(NBITS-3){1'b0}}, 3'b100};
  localparam logic [NBITS-1:0] PC_MASK = {{(NBITS-2){1'b1}}, 2'b00};

  logic [1:0]       state_r;
  logic [NBITS-1:0] pc_r;
  logic [NBITS-1:0] if_pc_r;
  logic [NBITS-1:0] if_instr_r;
  logic             if_valid_r;
  logic             step_pending_r;
  logic [NBITS-1:0] mem [MEM_DEPTH];

  logic [NBITS-1:0] fetch_word_s;
  logic [NBITS-1:0] pc_plus4_s;
  logic             fetch_en_s;

  assign fetch_word_s = mem[pc_r[ADDR_BITS+1:2]];
  assign pc_plus4_s   = pc_r + PC_INC;

  assign o_pc          = if_pc_r;
  assign o_instruction = if_instr_r;
  assign o_valid       = if_valid_r;
  assign o_cur_pc      = pc_r;
  assign o_halted      = (state_r == ST_HALTED);

  // Decide whether this cycle may perform a fetch action
  always_comb begin
    fetch_en_s = 1'b0;
    case (state_r)
      ST_RUN:  fetch_en_s = 1'b1;
      ST_STEP: fetch_en_s = step_pending_r;
      default: fetch_en_s = 1'b0;
    endcase
  end

  // Program loading; memory has no reset so a restart re-runs the loaded program
  always_ff @(posedge i_clk) begin
    if (i_rst && (state_r == ST_LOAD) && i_load_en) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  // PC, IF/ID register, step bookkeeping and state sequencing
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r        <= ST_LOAD;
      pc_r           <= '0;
      if_pc_r        <= '0;
      if_instr_r     <= '0;
      if_valid_r     <= 1'b0;
      step_pending_r <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if_instr_r <= '0;
          if_valid_r <= 1'b0;
          if (i_start) begin
            state_r <= i_step_mode ? ST_STEP : ST_RUN;
          end
        end
        ST_RUN, ST_STEP: begin
          if (i_stall) begin
            // hold; a concurrent redirect is re-asserted by decode after the stall
            if_valid_r <= if_valid_r;
          end else if (i_flg_jump_taken) begin
            pc_r       <= i_jump_addr & PC_MASK;
            if_instr_r <= '0;
            if_valid_r <= 1'b0;
          end else if (fetch_en_s) begin
            if_pc_r    <= pc_plus4_s;
            if_instr_r <= fetch_word_s;
            if_valid_r <= 1'b1;
            if (fetch_word_s == HALT_WORD) begin
              state_r <= ST_HALTED;
            end else begin
              pc_r <= pc_plus4_s;
            end
          end else begin
            if_instr_r <= '0;
            if_valid_r <= 1'b0;
          end
          if (state_r == ST_STEP) begin
            step_pending_r <= step_pending_r ? i_stall : i_step;
          end
        end
        ST_HALTED: begin
          if (!i_stall) begin
            if_instr_r <= '0;
            if_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed test-plan scenarios plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int M_LOAD = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst, load_en, start, step_mode, step, stall, jump;
  logic [5:0]  load_addr;
  logic [31:0] load_data, jump_addr;
  logic [31:0] o_pc, o_instruction, o_cur_pc;
  logic        o_valid, o_halted;

  int checks = 0;
  int errors = 0;

  // behavioural reference state
  logic [31:0] m_mem [64];
  logic [31:0] m_pc, m_ins;
  logic [31:0] m_opc;
  logic        m_valid, m_pend, m_reset_edge;
  int          m_mode;

  instruction_fetch_stage dut (
    .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_addr(load_addr),
    .i_load_data(load_data), .i_start(start), .i_step_mode(step_mode), .i_step(step),
    .i_stall(stall), .i_flg_jump_taken(jump), .i_jump_addr(jump_addr),
    .o_pc(o_pc), .o_instruction(o_instruction), .o_valid(o_valid),
    .o_cur_pc(o_cur_pc), .o_halted(o_halted)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // One clock edge of the reference: spec rules applied to the current inputs
  task automatic model_edge();
    logic doing_fetch;
    logic [31:0] word;
    m_reset_edge = 1'b0;
    if (!rst) begin
      m_pc = 0; m_opc = 0; m_ins = 0; m_valid = 0; m_mode = M_LOAD; m_pend = 0;
      m_reset_edge = 1'b1;
      return;
    end
    if (m_mode == M_LOAD) begin
      if (load_en) m_mem[load_addr] = load_data;
      m_ins = 0; m_valid = 0;
      if (start) m_mode = step_mode ? M_STEP : M_RUN;
    end else if (m_mode == M_HALT) begin
      if (!stall) begin m_ins = 0; m_valid = 0; end
    end else begin
      doing_fetch = (m_mode == M_RUN) || m_pend;
      if (m_mode == M_STEP) begin
        if (m_pend && !stall) m_pend = 0;
        else if (!m_pend) m_pend = step;
      end
      if (stall) begin
        // IF/ID and PC unchanged
      end else if (jump) begin
        m_pc = (jump_addr / 4) * 4;
        m_ins = 0; m_valid = 0;
      end else if (doing_fetch) begin
        word = m_mem[(m_pc / 4) % 64];
        m_opc = m_pc + 4; m_ins = word; m_valid = 1;
        if (word == HALT) m_mode = M_HALT;
        else m_pc = m_pc + 4;
      end else begin
        m_ins = 0; m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_value("cur_pc", o_cur_pc, m_pc);
    check_value("valid", {31'd0, o_valid}, {31'd0, m_valid});
    check_value("instr", o_instruction, m_ins);
    check_value("halted", {31'd0, o_halted}, {31'd0, (m_mode == M_HALT)});
    if (m_valid || m_reset_edge) check_value("if_pc", o_pc, m_opc);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(); rst = 1'b1;
  endtask

  task automatic go(input logic mode);
    start = 1'b1; step_mode = mode; tick(); start = 1'b0; step_mode = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0000_0020;
    return w;
  endfunction

  initial begin
    rst = 1'b0; load_en = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    stall = 1'b0; jump = 1'b0; load_addr = '0; load_data = '0; jump_addr = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
    @(negedge clk);
    ticks(2);
    rst = 1'b1;

    // program with HALT at word 3, random filler elsewhere
    for (int i = 0; i < 64; i++) load_word(6'(i), rand_word());
    load_word(6'd0, 32'h2001_0005);
    load_word(6'd1, 32'h2002_0007);
    load_word(6'd2, 32'h0022_1820);
    load_word(6'd3, HALT);
    go(1'b0);
    ticks(8);
    stall = 1'b1; ticks(2); stall = 1'b0;
    step = 1'b1; start = 1'b1; load_en = 1'b1; jump = 1'b1; tick();
    step = 1'b0; start = 1'b0; load_en = 1'b0; jump = 1'b0; ticks(2);

    // remove the HALT, then stall / redirect / stall+redirect in RUN
    do_reset();
    load_word(6'd3, 32'h0043_1020);
    go(1'b0);
    ticks(2);
    stall = 1'b1; ticks(3); stall = 1'b0; ticks(2);
    jump = 1'b1; jump_addr = 32'h0000_0023; tick(); jump = 1'b0; ticks(2);
    stall = 1'b1; jump = 1'b1; jump_addr = 32'h0000_0041; tick();
    stall = 1'b0; tick(); jump = 1'b0; ticks(2);

    // reset in the middle of RUN at pc 0x10, then restart from word 0
    do_reset();
    go(1'b0);
    ticks(4);
    check_value("pc_before_rst", o_cur_pc, 32'h0000_0010);
    do_reset();
    check_value("pc_after_rst", o_cur_pc, 32'h0000_0000);
    go(1'b0);
    ticks(3);

    // single-step mode, including a pulse during a stall and a double pulse
    do_reset();
    go(1'b1);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick(); step = 1'b0; ticks(4);
    end
    stall = 1'b1; step = 1'b1; tick(); step = 1'b0; ticks(2); stall = 1'b0; ticks(4);
    step = 1'b1; ticks(2); step = 1'b0; ticks(4);

    // randomized traffic with occasional HALT words and mid-run resets
    for (int r = 0; r < 30; r++) begin
      do_reset();
      for (int j = 0; j < 4; j++)
        load_word(6'($urandom_range(0, 63)), ($urandom_range(0, 7) == 0) ? HALT : rand_word());
      go(1'($urandom_range(0, 1)));
      for (int c = 0; c < 50; c++) begin
        stall     = ($urandom_range(0, 3) == 0);
        jump      = ($urandom_range(0, 9) == 0);
        jump_addr = $urandom;
        step      = ($urandom_range(0, 4) == 0);
        start     = ($urandom_range(0, 15) == 0);
        load_en   = ($urandom_range(0, 15) == 0);
        load_addr = 6'($urandom_range(0, 63));
        load_data = rand_word();
        rst       = ($urandom_range(0, 99) != 0);
        tick();
        if (!rst) begin
          rst = 1'b1; start = 1'b1; step_mode = 1'($urandom_range(0, 1)); load_en = 1'b0;
          tick();
          step_mode = 1'b0;
        end
      end
      stall = 1'b0; jump = 1'b0; step = 1'b0; start = 1'b0; load_en = 1'b0; rst = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
